// File: rtl/climate_ctrl_fsm_pkg.sv
// Shared definitions for the climate controller: state encodings and
// threshold arithmetic helpers.
package climate_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2,
    FAN     = 2'd3
  } state_t;

  // Unsigned subtract that floors at zero instead of wrapping.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/climate_ctrl_fsm_sample_debounce.sv
// Counts consecutive qualifying valid samples and pulses done on the edge
// that registers the DEB_N-th one.
module sample_debounce #(
  parameter int unsigned DEB_N = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic valid,
  input  logic hit,
  output logic done
);

  localparam int unsigned CW = (DEB_N > 1) ? $clog2(DEB_N) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_N - 1);

  logic [CW-1:0] cnt;

  // Combinational so the owning FSM can move on the same edge the sample lands.
  assign done = valid && hit && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (valid) begin
      if (!hit || done) cnt <= '0;
      else              cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/climate_ctrl_fsm.sv
// Temperature alarm/fan controller with hysteresis, sample debounce and a
// minimum fan-on hold time; Moore outputs registered alongside the state.
import climate_pkg::*;

module climate_ctrl_fsm #(
  parameter int          DATA_W   = 8,
  parameter int unsigned DEB_N    = 3,
  parameter int unsigned HOLD_CYC = 1000,
  parameter int          CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] temp,
  input  logic              temp_valid,
  input  logic [DATA_W-1:0] thr_alarm,
  input  logic [DATA_W-1:0] thr_fan,
  input  logic [DATA_W-1:0] hyst,
  output logic              en_alarma,
  output logic              en_ventilador,
  output logic [1:0]        estado,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  alarm_cnt
);

  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_t            state, state_n;
  logic [HOLD_W-1:0] hold;
  logic [DATA_W-1:0] lo_a, lo_f;
  logic              hit, clr, done;

  assign cfg_err = (thr_fan < thr_alarm);
  assign lo_a    = DATA_W'(sat_sub(32'(thr_alarm), 32'(hyst)));
  assign lo_f    = DATA_W'(sat_sub(32'(thr_fan), 32'(hyst)));
  assign estado  = state;

  // Exit qualification for whichever state we are in; ALARM has two exits
  // sharing one debounce count, the final sample picks the direction.
  always_comb begin
    hit = 1'b0;
    unique case (state)
      MONITOR: hit = (temp >= thr_alarm);
      ALARM:   hit = (temp >= thr_fan) || (temp < lo_a);
      FAN:     hit = (temp < lo_f);
      default: hit = 1'b0;
    endcase
  end

  assign clr = !en || (state == IDLE) || ((state == FAN) && (hold != '0));

  sample_debounce #(.DEB_N(DEB_N)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .valid (temp_valid),
    .hit   (hit),
    .done  (done)
  );

  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (!cfg_err) state_n = MONITOR;
        MONITOR: if (done)     state_n = ALARM;
        ALARM:   if (done)     state_n = (temp >= thr_fan) ? FAN : MONITOR;
        FAN:     if (done)     state_n = ALARM;
        default:               state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      en_alarma     <= 1'b0;
      en_ventilador <= 1'b0;
      hold          <= '0;
      alarm_cnt     <= '0;
    end else begin
      state         <= state_n;
      en_alarma     <= (state_n == ALARM) || (state_n == FAN);
      en_ventilador <= (state_n == FAN);

      if (!en)
        hold <= '0;
      else if ((state != FAN) && (state_n == FAN))
        hold <= HOLD_W'(HOLD_CYC - 1);
      else if ((state == FAN) && (hold != '0))
        hold <= hold - 1'b1;

      if ((state == MONITOR) && (state_n == ALARM) && (alarm_cnt != '1))
        alarm_cnt <= alarm_cnt + 1'b1;
    end
  end

endmodule
